// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-extension unit.
// Build option: IMMEXT_PC_ADD_EN carries the PC through S1 for absolute branch targets.
package imm_pkg;

  typedef enum logic [1:0] {
    MODE_BRANCH = 2'b00,
    MODE_DP_ROT = 2'b01,
    MODE_MEM12  = 2'b10,
    MODE_RSVD   = 2'b11
  } imm_mode_e;

  // ARM reads the PC two instructions ahead.
  localparam int unsigned PC_BIAS = 8;

  // S1 payload alongside the extended value, whose width follows the top-level DATA_W.
  typedef struct packed {
`ifdef IMMEXT_PC_ADD_EN
    logic [31:0] pc;
`endif
    imm_mode_e   mode;
    logic        shc;
    logic        err;
  } s1_meta_t;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Decode-side request and execute-side result channels of the immediate-extension unit.
interface imm_ext_if #(
  parameter int unsigned DATA_W = 32
) ();
  import imm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  imm_mode_e         in_mode;
  logic              in_c;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_shc;
  logic              out_err;

  modport slave (
    input  in_valid, in_instr, in_pc, in_mode, in_c, out_ready,
    output in_ready, out_valid, out_data, out_shc, out_err
  );

  modport master (
    output in_valid, in_instr, in_pc, in_mode, in_c, out_ready,
    input  in_ready, out_valid, out_data, out_shc, out_err
  );

endinterface

// File: rtl/imm_pipe_stage.sv
// Generic valid/ready register slice; loads when empty or when downstream accepts.
module imm_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Two-stage immediate extender: combinational extraction, S1 register, S2 result register.
// Build option: IMMEXT_PC_ADD_EN turns BRANCH results into pc + 8 + offset.
module imm_extend_unit
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BR_SHIFT = 2
) (
  input logic      clk,
  input logic      rst_n,
  imm_ext_if.slave bus
);

  localparam int unsigned S1W = DATA_W + $bits(s1_meta_t);
  localparam int unsigned S2W = DATA_W + 2;

  logic [DATA_W-1:0] br_sext;
  logic [4:0]        rot_amt;
  logic [31:0]       imm8_w;
  logic [31:0]       rot_val;
  logic [DATA_W-1:0] mem_val;
  logic [DATA_W-1:0] ext_value;
  s1_meta_t          ext_meta;

  always_comb begin
    br_sext = {{(DATA_W-24){bus.in_instr[23]}}, bus.in_instr[23:0]};
    rot_amt = {bus.in_instr[11:8], 1'b0};
    imm8_w  = {24'd0, bus.in_instr[7:0]};
    // A left shift by 32 yields zero, so rot_amt = 0 needs no special case.
    rot_val = (imm8_w >> rot_amt) | (imm8_w << (6'd32 - {1'b0, rot_amt}));
    mem_val = DATA_W'(bus.in_instr[11:0]);
    if (!bus.in_instr[23]) begin
      mem_val = '0 - mem_val;
    end

    ext_value     = '0;
    ext_meta      = '0;
    ext_meta.mode = bus.in_mode;
    ext_meta.shc  = bus.in_c;
`ifdef IMMEXT_PC_ADD_EN
    ext_meta.pc   = bus.in_pc;
`endif
    unique case (bus.in_mode)
      MODE_BRANCH: ext_value = br_sext << BR_SHIFT;
      MODE_DP_ROT: begin
        ext_value = DATA_W'(rot_val);
        if (bus.in_instr[11:8] != 4'd0) begin
          ext_meta.shc = rot_val[31];
        end
      end
      MODE_MEM12:  ext_value = mem_val;
      default:     ext_meta.err = 1'b1;
    endcase
  end

  logic [S1W-1:0]    s1_in_data, s1_out_data;
  logic              s1_valid, s2_in_ready;
  logic [DATA_W-1:0] s1_value;
  s1_meta_t          s1_meta;

  assign s1_in_data          = {ext_value, ext_meta};
  assign {s1_value, s1_meta} = s1_out_data;

  imm_pipe_stage #(.Width(S1W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_out_data)
  );

  logic [DATA_W-1:0] s2_result;
  logic [S2W-1:0]    s2_in_data, s2_out_data;

  always_comb begin
    s2_result = s1_value;
`ifdef IMMEXT_PC_ADD_EN
    if (s1_meta.mode == MODE_BRANCH) begin
      s2_result = s1_value + DATA_W'(s1_meta.pc) + DATA_W'(PC_BIAS);
    end
`endif
  end

`ifndef IMMEXT_PC_ADD_EN
  logic unused_cfg;
  assign unused_cfg = ^{bus.in_pc, s1_meta.mode};
`endif

  logic unused_instr;
  assign unused_instr = ^bus.in_instr[31:24];

  assign s2_in_data = {s2_result, s1_meta.shc, s1_meta.err};

  imm_pipe_stage #(.Width(S2W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_out_data)
  );

  assign {bus.out_data, bus.out_shc, bus.out_err} = s2_out_data;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed vectors, stalls, mid-stream reset, random.
module tb_imm_extend_unit;
  import imm_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned BRS = 2;
`ifdef IMMEXT_PC_ADD_EN
  localparam bit          UsePc = 1'b1;
  localparam logic [31:0] BrExp = 32'h0000_1000;
`else
  localparam bit          UsePc = 1'b0;
  localparam logic [31:0] BrExp = 32'hFFFF_FFF8;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        shc;
    logic        err;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  mode;
    logic        c;
    res_t        exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;
  bit   rand_done;
  obs_t obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_ext_if #(.DATA_W(DW)) bus ();

  imm_extend_unit #(.DATA_W(DW), .BR_SHIFT(BRS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Records every result handshake that will complete on the next rising edge.
  always @(negedge clk) begin : mon
    obs_t o;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      o.r   = {bus.out_data, bus.out_shc, bus.out_err};
      o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Reference: arithmetic straight from the mode definitions.
  function automatic res_t ref_model(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic [1:0] mode, input logic c);
    res_t        res;
    longint      v;
    logic [31:0] r;
    int          rot;
    res.data = '0;
    res.shc  = c;
    res.err  = 1'b0;
    case (mode)
      2'd0: begin
        v = longint'(instr[23:0]);
        if (instr[23]) v = v - 64'sd16777216;
        v = v * (longint'(1) << BRS);
        if (UsePc) v = v + longint'(pc) + longint'(PC_BIAS);
        res.data = v[31:0];
      end
      2'd1: begin
        rot = int'(instr[11:8]);
        r   = {24'd0, instr[7:0]};
        for (int i = 0; i < 2 * rot; i++) r = {r[0], r[31:1]};
        res.data = r;
        if (rot != 0) res.shc = r[31];
      end
      2'd2: begin
        v = longint'(instr[11:0]);
        if (!instr[23]) v = -v;
        res.data = v[31:0];
      end
      default: res.err = 1'b1;
    endcase
    return res;
  endfunction

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] mode,
                      input logic c, output bit ok);
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.in_mode  = imm_mode_e'(mode);
    bus.in_c     = c;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      ok = acc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.in_mode = MODE_BRANCH; bus.in_c = 1'b0; bus.out_ready = 1'b0;
    #3;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== '0) $display("FAIL reset out_data: got %h want 0", bus.out_data); else passed++;
    total++; if (bus.out_shc !== 1'b0) $display("FAIL reset out_shc: got %b want 0", bus.out_shc); else passed++;
    total++; if (bus.out_err !== 1'b0) $display("FAIL reset out_err: got %b want 0", bus.out_err); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", bus.in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    vec_t vecs[7];
    bit   ok;
    vecs[0] = '{32'h00FF_FFFE, 32'h0000_1000, 2'd0, 1'b0, '{BrExp,        1'b0, 1'b0}};
    vecs[1] = '{32'h0000_04FF, 32'h0,         2'd1, 1'b0, '{32'hFF00_0000, 1'b1, 1'b0}};
    vecs[2] = '{32'h0000_00FF, 32'h0,         2'd1, 1'b1, '{32'h0000_00FF, 1'b1, 1'b0}};
    vecs[3] = '{32'h0000_0004, 32'h0,         2'd2, 1'b0, '{32'hFFFF_FFFC, 1'b0, 1'b0}};
    vecs[4] = '{32'h0080_0004, 32'h0,         2'd2, 1'b1, '{32'h0000_0004, 1'b1, 1'b0}};
    vecs[5] = '{32'hE300_0123, 32'h0000_2000, 2'd3, 1'b1, '{32'h0,         1'b1, 1'b1}};
    vecs[6] = '{32'h0080_0010, 32'h0,         2'd2, 1'b0, '{32'h0000_0010, 1'b0, 1'b0}};
    bus.out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].instr, vecs[i].pc, vecs[i].mode, vecs[i].c, ok);
      total++; if (!ok) $display("FAIL directed[%0d] accept: got timeout want handshake", i); else passed++;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) $display("FAIL directed[%0d] early out_valid: got %b want 0", i, bus.out_valid); else passed++;
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1) $display("FAIL directed[%0d] out_valid: got %b want 1", i, bus.out_valid); else passed++;
      total++; if (bus.out_data !== vecs[i].exp.data) $display("FAIL directed[%0d] out_data: got %h want %h", i, bus.out_data, vecs[i].exp.data); else passed++;
      total++; if (bus.out_shc !== vecs[i].exp.shc) $display("FAIL directed[%0d] out_shc: got %b want %b", i, bus.out_shc, vecs[i].exp.shc); else passed++;
      total++; if (bus.out_err !== vecs[i].exp.err) $display("FAIL directed[%0d] out_err: got %b want %b", i, bus.out_err, vecs[i].exp.err); else passed++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[3];
    logic [31:0] pcs[3];
    logic [1:0]  mds[3];
    logic        cs[3];
    res_t        exp[3];
    bit          ok;
    int          waited;
    for (int i = 0; i < 3; i++) begin
      ins[i] = $urandom; pcs[i] = $urandom; mds[i] = 2'($urandom_range(0, 2)); cs[i] = 1'($urandom_range(0, 1));
      exp[i] = ref_model(ins[i], pcs[i], mds[i], cs[i]);
    end
    obs_q.delete();
    bus.out_ready = 1'b0;
    send(ins[0], pcs[0], mds[0], cs[0], ok);
    total++; if (!ok) $display("FAIL b2b accept A: got timeout want handshake"); else passed++;
    send(ins[1], pcs[1], mds[1], cs[1], ok);
    total++; if (!ok) $display("FAIL b2b accept B: got timeout want handshake"); else passed++;
    bus.in_valid = 1'b1; bus.in_instr = ins[2]; bus.in_pc = pcs[2];
    bus.in_mode = imm_mode_e'(mds[2]); bus.in_c = cs[2];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b full in_ready[%0d]: got %b want 0", k, bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b1) $display("FAIL b2b stall out_valid[%0d]: got %b want 1", k, bus.out_valid); else passed++;
      total++; if ({bus.out_data, bus.out_shc, bus.out_err} !== exp[0]) $display("FAIL b2b stall hold[%0d]: got %h/%b/%b want %h/%b/%b", k, bus.out_data, bus.out_shc, bus.out_err, exp[0].data, exp[0].shc, exp[0].err); else passed++;
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b release in_ready: got %b want 1", bus.in_ready); else passed++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    waited = 0;
    while (obs_q.size() < 3 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    total++; if (obs_q.size() != 3) $display("FAIL b2b result count: got %0d want 3", obs_q.size()); else passed++;
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i].r !== exp[i]) $display("FAIL b2b order[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_q[i].r.data, obs_q[i].r.shc, obs_q[i].r.err, exp[i].data, exp[i].shc, exp[i].err); else passed++;
      if (i > 0) begin
        total++; if (obs_q[i].cyc != obs_q[i-1].cyc + 1) $display("FAIL b2b gap[%0d]: got cycle %0d want %0d", i, obs_q[i].cyc, obs_q[i-1].cyc + 1); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    int   waited;
    res_t exp;
    obs_q.delete();
    bus.out_ready = 1'b0;
    send(32'h00FF_FFF0, 32'h4000, 2'd0, 1'b0, ok);
    send(32'h0000_0004, 32'h0,    2'd2, 1'b1, ok);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL rst_mid pre out_valid: got %b want 1", bus.out_valid); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid async out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_mid in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_data !== '0) $display("FAIL rst_mid out_data: got %h want 0", bus.out_data); else passed++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (obs_q.size() != 0) $display("FAIL rst_mid ghost beats: got %0d want 0", obs_q.size()); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_mid post in_ready: got %b want 1", bus.in_ready); else passed++;
    exp = ref_model(32'h0000_0A3F, 32'h0, 2'd1, 1'b0);
    send(32'h0000_0A3F, 32'h0, 2'd1, 1'b0, ok);
    total++; if (!ok) $display("FAIL rst_mid accept: got timeout want handshake"); else passed++;
    waited = 0;
    while (obs_q.size() < 1 && waited < 10) begin
      @(posedge clk); #1; waited++;
    end
    total++; if (obs_q.size() != 1) $display("FAIL rst_mid result count: got %0d want 1", obs_q.size()); else passed++;
    if (obs_q.size() > 0) begin
      total++; if (obs_q[0].r !== exp) $display("FAIL rst_mid result: got %h/%b/%b want %h/%b/%b", obs_q[0].r.data, obs_q[0].r.shc, obs_q[0].r.err, exp.data, exp.shc, exp.err); else passed++;
    end
  endtask

  task automatic test_random();
    localparam int N = 200;
    res_t        exp_q[$];
    logic [31:0] instr, pc;
    logic [1:0]  mode;
    logic        c;
    bit          ok;
    int          timeouts = 0;
    int          waited;
    obs_q.delete();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          instr = $urandom; pc = $urandom; mode = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(instr, pc, mode, c, ok);
          if (ok) exp_q.push_back(ref_model(instr, pc, mode, c));
          else timeouts++;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    waited = 0;
    while (obs_q.size() < exp_q.size() && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    total++; if (timeouts != 0) $display("FAIL random accept: got %0d timeouts want 0", timeouts); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i].r !== exp_q[i]) $display("FAIL random[%0d]: got %h/%b/%b want %h/%b/%b", i, obs_q[i].r.data, obs_q[i].r.shc, obs_q[i].r.err, exp_q[i].data, exp_q[i].shc, exp_q[i].err); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Pipelined immediate-extension unit for the ARM core's decode path, replacing the fixed 24-bit branch sign-extender. Takes a 32-bit instruction word plus its PC, extracts and extends the immediate for the selected mode, and returns a DATA_W-bit operand or branch target. Sits between instruction decode and the execute-stage operand mux. Uses a two-stage valid/ready pipeline so decode stalls propagate without loss.

## Interface
- DATA_W, 32: result width; must be ≥ 32.
- BR_SHIFT, 2: left shift applied to the branch offset; 0–3.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  address of in_instr
- in_mode  in  2  00 BRANCH, 01 DP_ROT, 10 MEM12, 11 reserved
- in_c  in  1  current C flag, used for the DP_ROT carry
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  DATA_W  extended immediate or branch target
- out_shc  out  1  shifter carry-out (DP_ROT), else in_c
- out_err  out  1  reserved mode was presented

## Operation
- A transfer occurs on a cycle where valid && ready are both high, at either port.
- BRANCH: off = sign-extend(instr[23:0]) << BR_SHIFT, computed at DATA_W bits; bits shifted out above DATA_W are discarded.
- DP_ROT: r = instr[7:0] rotated right by 2·instr[11:8] within 32 bits, then zero-extended to DATA_W.
  - out_shc = r[31] when instr[11:8] ≠ 0, else in_c.
- MEM12: value = instr[11:0] zero-extended. If instr[23] (U) = 0, the result is the two's-complement negation (DATA_W bits).
- Reserved mode: out_data = 0, out_err = 1, out_shc = in_c.
- Stage 1 (S1) registers: extended value, mode, pc, shc, err.
- Stage 2 (S2) registers: final result. For BRANCH with IMMEXT_PC_ADD_EN defined, the result is pc + 8 + off, modulo 2^DATA_W, with pc zero-extended.
- Every stage advances when it is empty or the stage downstream accepts.
- Each stage holds its contents while stalled.
- Beats are never dropped, duplicated or reordered.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_shc = 0, out_err = 0, in_ready = 1, both stage valids = 0.
- Latency: 2 cycles from the input handshake to out_valid, with no stall.
- Throughput: 1 beat per cycle.
- in_ready = !s1_valid || !s2_valid || out_ready. It is combinational from out_ready; there is no path from in_valid to in_ready.
- out_data, out_shc and out_err are stable while out_valid && !out_ready.
- Full condition: both stages valid and out_ready = 0, so in_ready = 0.
- Output drained and input arriving in the same cycle: S2 loads from S1 and S1 loads the new beat, both in that cycle.
- Reset asserted mid-stream: all in-flight beats are discarded immediately (asynchronous). The first accept is possible on the first clock edge after deassertion.

## Configuration
- IMMEXT_PC_ADD_EN defined: the BRANCH result is the absolute target pc + 8 + off.
- IMMEXT_PC_ADD_EN undefined: the BRANCH result is off only. The S2 adder and the S1 pc register are omitted, and in_pc is ignored.
- Latency and handshake are identical in both builds.

## Structure
- Shared package imm_pkg holds:
  - the mode enum (MODE_BRANCH, MODE_DP_ROT, MODE_MEM12, MODE_RSVD);
  - the PC_BIAS = 8 constant;
  - the S1 payload struct.
- Sub-module imm_pipe_stage: one generic valid/ready register slice parameterised on payload width, instantiated twice.
- The extension logic is combinational in the top level, ahead of S1.

## Test plan
- BRANCH, instr[23:0] = 0xFFFFFE, pc = 0x1000, macro on -> out_data = 0x00001000, out_err = 0, two cycles after accept. With the macro off -> 0xFFFFFFF8.
- DP_ROT, imm8 = 0xFF, rot = 4, in_c = 0 -> out_data = 0xFF000000, out_shc = 1. Same beat with rot = 0, in_c = 1 -> 0x000000FF, out_shc = 1.
- MEM12, imm12 = 0x004: U = 0 -> 0xFFFFFFFC; U = 1 -> 0x00000004.
- Mode 11 -> out_data = 0, out_err = 1; the following valid beat has out_err = 0.
- Back-to-back beats A, B, C with out_ready held low 3 cycles:
  - in_ready falls after A and B are accepted;
  - C is held at the input;
  - after release, outputs are A, B, C in order with no gaps.
- rst_n pulsed low with 2 beats in flight -> out_valid drops asynchronously; neither beat ever appears; in_ready = 1 after reset.
